// File: rtl/transpose_row_loader.sv
// transpose_row_loader: packs streamed matrix rows into ping-pong buffers read over the openMSP430 peripheral bus
module transpose_row_loader #(
  parameter logic [13:0] BASE_ADDR = 14'h090
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        irq
);
  logic [1:0][3:0][15:0] mem;
  logic                  wr_sel, rd_sel, ie;
  logic [1:0]            cnt;
  logic [2:0]            byte_idx;
  logic [13:0]           off;
  logic [1:0]            widx;
  logic [15:0]           ctrl;
  logic                  bus_wr, bus_rd, ctrl_wr, flush, pop, acc, done;
  assign off      = per_addr - BASE_ADDR;
  assign widx     = off[1:0] - 2'd1;
  assign bus_wr   = per_en & (per_we == 2'b11);
  assign bus_rd   = per_en & (per_we == 2'b00);
  assign ctrl_wr  = bus_wr & (off == 14'd0);
  assign flush    = ctrl_wr & per_din[3];
  assign pop      = ctrl_wr & per_din[0] & (cnt != 2'd0) & ~flush;
  assign s_ready  = (cnt != 2'd2) & ~flush;
  assign acc      = s_valid & s_ready;
  assign done     = acc & (byte_idx == 3'd7);
  assign ctrl     = {9'b0, byte_idx, 1'b0, ie, cnt == 2'd2, cnt != 2'd0};
  always_comb
    per_dout = !bus_rd ? 16'h0 :
               off == 14'd0 ? ctrl :
               (off >= 14'd1 && off <= 14'd4 && cnt != 2'd0) ? mem[rd_sel][widx] : 16'h0;
  always_ff @(posedge mclk or negedge puc_rst_n)
    if (!puc_rst_n) begin
      mem      <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      cnt      <= 2'd0;
      byte_idx <= 3'd0;
      ie       <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (acc) mem[wr_sel][byte_idx[2:1]][{byte_idx[0], 3'b0} +: 8] <= s_data;
      byte_idx <= flush ? 3'd0 : byte_idx + {2'b0, acc};
      wr_sel   <= flush ? 1'b0 : wr_sel ^ done;
      rd_sel   <= flush ? 1'b0 : rd_sel ^ pop;
      cnt      <= flush ? 2'd0 : cnt + {1'b0, done} - {1'b0, pop};
      if (ctrl_wr) ie <= per_din[2];
      irq <= ie & (cnt != 2'd0);
    end
endmodule

// File: tb/tb_transpose_row_loader.sv
// tb_transpose_row_loader: table, directed and randomized checks against a queue-based matrix model
module tb_transpose_row_loader;
  localparam logic [13:0] B = 14'h090;
  logic        mclk = 1'b0, puc_rst_n = 1'b0;
  logic [13:0] per_addr;
  logic [15:0] per_din, per_dout;
  logic        per_en, s_valid, s_ready, irq;
  logic [1:0]  per_we;
  logic [7:0]  s_data;
  int total = 0, bad = 0;
  logic [63:0] mats[$];
  logic [63:0] part;
  int          pidx;
  logic        m_ie, m_irq;
  typedef struct {
    logic [13:0] a; logic [1:0] we; logic en; logic [15:0] d;
    logic v; logic [7:0] sd; logic rdy; logic [15:0] dout;
  } vec_t;
  vec_t tbl[19];

  transpose_row_loader #(.BASE_ADDR(B)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .irq(irq)
  );

  always #5 mclk = ~mclk;

  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic drv(logic [13:0] a, logic [1:0] we, logic en, logic [15:0] d, logic v, logic [7:0] sd);
    per_addr = a; per_we = we; per_en = en; per_din = d; s_valid = v; s_data = sd;
  endtask

  task automatic mreset();
    mats.delete(); part = '0; pidx = 0; m_ie = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [15:0] exp_dout();
    logic [13:0] o;
    logic [63:0] m;
    o = per_addr - B;
    if (!(per_en && per_we == 2'b00)) return 16'h0;
    if (o == 0) return {9'b0, 3'(pidx), 1'b0, m_ie, 1'(mats.size() == 2), 1'(mats.size() != 0)};
    if (o >= 1 && o <= 4 && mats.size() != 0) begin
      m = mats[0];
      return m[16*(int'(o)-1) +: 16];
    end
    return 16'h0;
  endfunction

  // checks outputs against the model before the edge, then advances the model across it
  task automatic step();
    bit cw, fl, pp, ac;
    cw = per_en && per_we == 2'b11 && per_addr == B;
    fl = cw && per_din[3];
    pp = cw && per_din[0] && !fl && mats.size() != 0;
    ac = s_valid && mats.size() != 2 && !fl;
    #1;
    chk("s_ready", 16'(s_ready), 16'(mats.size() != 2 && !fl));
    chk("per_dout", per_dout, exp_dout());
    chk("irq", 16'(irq), 16'(m_irq));
    m_irq = m_ie && mats.size() != 0;
    if (cw) m_ie = per_din[2];
    if (fl) begin mats.delete(); pidx = 0; end
    if (pp) void'(mats.pop_front());
    if (ac) begin
      part[pidx*8 +: 8] = s_data;
      pidx++;
      if (pidx == 8) begin mats.push_back(part); pidx = 0; end
    end
    @(negedge mclk);
  endtask

  task automatic send(logic [7:0] b);
    drv(14'h0, 2'b00, 1'b0, 16'h0, 1'b1, b);
    step();
  endtask

  task automatic idle();
    drv(14'h0, 2'b00, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  initial begin
    mreset();
    idle();
    for (int i = 0; i < 8; i++) tbl[i] = '{14'h0, 2'b00, 1'b0, 16'h0, 1'b1, 8'(1 << i), 1'b1, 16'h0};
    tbl[8]  = '{B,     2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0001};
    tbl[9]  = '{B + 1, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0201};
    tbl[10] = '{B + 2, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0804};
    tbl[11] = '{B + 3, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h2010};
    tbl[12] = '{B + 4, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h8040};
    tbl[13] = '{B + 5, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0000};
    tbl[14] = '{B + 1, 2'b01, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0000};
    tbl[15] = '{B + 1, 2'b11, 1'b1, 16'hFFFF, 1'b0, 8'h0, 1'b1, 16'h0000};
    tbl[16] = '{B,     2'b10, 1'b1, 16'hFFFF, 1'b0, 8'h0, 1'b1, 16'h0000};
    tbl[17] = '{B + 1, 2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0201};
    tbl[18] = '{B,     2'b00, 1'b1, 16'h0,    1'b0, 8'h0, 1'b1, 16'h0001};
    @(negedge mclk);
    drv(B, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1;
    chk("rst_ready", 16'(s_ready), 16'h1);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_ctrl", per_dout, 16'h0);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    foreach (tbl[i]) begin
      drv(tbl[i].a, tbl[i].we, tbl[i].en, tbl[i].d, tbl[i].v, tbl[i].sd);
      #1;
      chk($sformatf("tbl%0d_ready", i), 16'(s_ready), 16'(tbl[i].rdy));
      chk($sformatf("tbl%0d_dout", i), per_dout, tbl[i].dout);
      step();
    end
    // back-pressure with two full matrices
    drv(B, 2'b11, 1'b1, 16'h0001, 1'b0, 8'h0); step();
    for (int i = 0; i < 16; i++) begin drv(B, 2'b00, 1'b1, 16'h0, 1'b1, 8'(8'h10 + i)); step(); end
    drv(B, 2'b00, 1'b1, 16'h0, 1'b1, 8'hAA);
    #1;
    chk("bp_ctrl", per_dout, 16'h0003);
    chk("bp_ready", 16'(s_ready), 16'h0);
    step(); step();
    drv(B, 2'b11, 1'b1, 16'h0001, 1'b1, 8'hAA); step();
    drv(B + 1, 2'b00, 1'b1, 16'h0, 1'b1, 8'hAA);
    #1;
    chk("bp_ready_after_pop", 16'(s_ready), 16'h1);
    chk("bp_w0", per_dout, 16'h1918);
    step();
    drv(B, 2'b11, 1'b1, 16'h0008, 1'b0, 8'h0); step();
    // interrupt rise and fall
    drv(B, 2'b11, 1'b1, 16'h0004, 1'b0, 8'h0); step();
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    idle();
    #1; chk("irq_lag", 16'(irq), 16'h0);
    step();
    #1; chk("irq_rise", 16'(irq), 16'h1);
    step();
    drv(B, 2'b11, 1'b1, 16'h0005, 1'b0, 8'h0); step();
    drv(B, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("irq_pop_ctrl", per_dout, 16'h0004);
    step();
    #1; chk("irq_fall", 16'(irq), 16'h0);
    step();
    // completion and pop in the same cycle
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
    for (int i = 0; i < 7; i++) send(8'(8'hB0 + i));
    drv(B, 2'b11, 1'b1, 16'h0001, 1'b1, 8'hB7); step();
    drv(B, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("sim_ctrl", per_dout, 16'h0001);
    step();
    drv(B + 1, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("sim_w0", per_dout, 16'hB1B0);
    step();
    drv(B + 4, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("sim_w3", per_dout, 16'hB7B6);
    step();
    // flush beats a concurrent stream byte
    drv(B, 2'b11, 1'b1, 16'h0008, 1'b0, 8'h0); step();
    for (int i = 0; i < 3; i++) send(8'(8'h50 + i));
    drv(B, 2'b11, 1'b1, 16'h0008, 1'b1, 8'hEE);
    #1; chk("fl_ready", 16'(s_ready), 16'h0);
    step();
    drv(B, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("fl_ctrl", per_dout, 16'h0000);
    step();
    for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
    drv(B + 1, 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
    #1; chk("fl_w0", per_dout, 16'hC1C0);
    step();
    // asynchronous reset mid-matrix
    drv(B, 2'b11, 1'b1, 16'h0008, 1'b0, 8'h0); step();
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i));
    drv(B, 2'b00, 1'b1, 16'h0, 1'b1, 8'h77);
    #3 puc_rst_n = 1'b0;
    #1;
    chk("ar_ready", 16'(s_ready), 16'h1);
    chk("ar_ctrl", per_dout, 16'h0000);
    per_we = 2'b01;
    #1; chk("ar_we01", per_dout, 16'h0000);
    mreset();
    @(negedge mclk);
    puc_rst_n = 1'b1;
    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] d;
      r = int'($urandom_range(0, 15));
      d = 16'($urandom);
      d[3] = ($urandom_range(0, 7) == 0);
      if (r < 10)      drv(B + 14'($urandom_range(0, 5)), 2'b00, 1'b1, 16'h0, 1'b0, 8'h0);
      else if (r < 13) drv(B, 2'b11, 1'b1, d, 1'b0, 8'h0);
      else if (r < 14) drv(B + 14'($urandom_range(0, 4)), 2'($urandom_range(1, 2)), 1'b1, d, 1'b0, 8'h0);
      else             drv(B, 2'b00, 1'b0, 16'h0, 1'b0, 8'h0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
